serial_link: RTL
================

Name: serial_link

Overview:
- SoC serial port responder for the SB (FF01) and SC (FF02) registers.
- Serves the MMIO register strobes sb_read, sc_read, n_sb_write and sc_write on the internal data bus d.
- Runs the 8-bit shift transfer using either an internal clock derived from lfo_16384Hz or an external SCK pin.
- Returns the serial interrupt request int_serial to the interrupt logic in MMIO.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the asynchronous inputs sck_in and sin (minimum 2).

Ports:
- clk2  input  1  system clock; single clock domain
- reset  input  1  synchronous, active-high reset
- d  inout  8  internal data bus; driven only while sb_read or sc_read is high, otherwise Z
- sb_read  input  1  MMIO strobe: drive SB onto d
- sc_read  input  1  MMIO strobe: drive SC onto d
- n_sb_write  input  1  MMIO strobe, active low: load SB from d
- sc_write  input  1  MMIO strobe: load SC from d
- lfo_16384Hz  input  1  divider level from MMIO; each rising edge is one internal half-bit tick
- sck_in  input  1  external SCK pad input (asynchronous)
- sin  input  1  serial data pad input (asynchronous)
- sck_out  output  1  SCK driven to pad
- sck_oe  output  1  pad drive enable for SCK; 1 when SC.clk_sel=1
- sout  output  1  serial data out to pad
- int_serial  output  1  one-cycle interrupt request at transfer completion

Behaviour:
- Reset values:
  - SB=0x00, SC.start=0, SC.clk_sel=0, bit count=0.
  - sck_out=1, sck_oe=0, sout=1, int_serial=0, d=Z.
  - Synchronizer and edge detector history set to 1.
- Register reads (combinational while the strobe is high):
  - sb_read: d=SB.
  - sc_read: d={start,6'b111111,clk_sel}.
  - Both read strobes high is illegal; SB has priority.
- Register writes (take effect at the clk2 edge where the strobe is active; a multi-cycle strobe re-applies every cycle, which is harmless):
  - n_sb_write low: SB<=d. This overrides any shift in the same cycle.
  - sc_write: start<=d[7], clk_sel<=d[0], bit count<=0.
  - sc_write with start=0 aborts a transfer in progress: no interrupt, SB keeps its partially shifted value, sck_out returns to 1.
- Edge detection: sck_in and sin pass through SYNC_STAGES flops. Edges are detected against a registered previous value, and each detected edge is a one-cycle pulse.
- Internal clock mode (clk_sel=1, start=1):
  - Each lfo_16384Hz rising edge toggles sck_out, giving an 8192 Hz bit rate.
  - When start=0, sck_out is held at 1 and lfo edges are ignored.
- External clock mode (clk_sel=0):
  - sck_oe=0; the shift clock is synchronized sck_in.
  - Edges are ignored while start=0.
- Shift clock (internal or external), per bit:
  - Falling edge: sout<=SB[7].
  - Rising edge: SB<={SB[6:0],sin_sync}, bit count+1.
- Completion:
  - On the rising edge that brings the count to 8 (3-bit wrap to 0), in the same cycle: start<=0.
  - int_serial=1 in the following cycle only.
  - sout holds its last value.
- Simultaneous events:
  - sc_write in the same cycle as a completing edge: the sc_write wins, and int_serial is not raised.
  - n_sb_write on a rising shift edge: the written value wins, but the bit count still increments.
- sout idles at 1 after reset.
- Reset mid-transfer: everything returns to reset values on the next clk2 edge, with no int_serial.

Decomposition:
- serial_pkg holds:
  - SB_ADDR=8'h01 and SC_ADDR=8'h02 (documentation only).
  - SC_START_BIT=7, SC_CLKSEL_BIT=0, SC_READ_ONES=6'b111111.
  - SB_RESET=8'h00, BIT_COUNT_W=3.
- Sub-module serial_edge_sync (SYNC_STAGES synchronizer plus rise/fall pulse outputs, reset to 1). It is instantiated twice: for sck_in, and for lfo_16384Hz without extra sync stages.
- sin uses only the synchronizer part.

Test Plan:
- Reset then reads:
  - Assert reset 2 cycles, then pulse sb_read → d=0x00.
  - sc_read → d=0x7E.
  - sck_out=1, sout=1, int_serial=0.
- Internal transfer:
  - Write SB=0xA5, SC=0x81, tie sin=1, toggle lfo_16384Hz.
  - sout sequence on successive SCK falls = 1,0,1,0,0,1,0,1.
  - After 16 lfo rises: int_serial high exactly 1 cycle, SB=0xFF, sc_read → 0x7F.
- External transfer:
  - Write SB=0x3C, SC=0x80, drive sck_in 8 pulses with sin pattern 0x96.
  - sck_oe=0, SB=0x96, one int_serial pulse.
  - No shift occurs before the SC write.
- Abort:
  - Start an internal transfer and write SC=0x01 after 3 rising shift edges.
  - No int_serial; sck_out=1.
  - A restart with SC=0x81 needs a full 8 bits before interrupting.
- Collision:
  - Issue sc_write=0x81 in the same cycle as the 8th rising edge.
  - No int_serial; start=1, bit count=0.
- Reset mid-transfer:
  - Assert reset after 5 bits.
  - All outputs return to reset values on the next clk2 edge; int_serial never pulses.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared constants and helpers for the serial port responder
// Purpose: register field positions, reset values and the SC read formatter.
// Ports: none (package).
package serial_pkg;

  // MMIO offsets of the two registers (the bus decode lives in MMIO, not here).
  typedef enum logic [7:0] {
    SB_ADDR = 8'h01,
    SC_ADDR = 8'h02
  } serial_reg_e;

  localparam int          SC_START_BIT  = 7;
  localparam int          SC_CLKSEL_BIT = 0;
  localparam logic [5:0]  SC_READ_ONES  = 6'b111111;
  localparam logic [7:0]  SB_RESET      = 8'h00;
  localparam int          BIT_COUNT_W   = 3;

  // Unimplemented SC bits read back as ones.
  function automatic logic [7:0] sc_read_value(input logic start, input logic clk_sel);
    return {start, SC_READ_ONES, clk_sel};
  endfunction

endpackage

// File: rtl/serial_if.sv
// rtl/serial_if.sv - MMIO strobe and interrupt bundle between MMIO and the serial port
// Purpose: groups the register access strobes and the interrupt request.
// Ports: sb_read, sc_read, n_sb_write (active low), sc_write from MMIO; int_serial back to MMIO.
interface serial_if;

  logic sb_read;
  logic sc_read;
  logic n_sb_write;
  logic sc_write;
  logic int_serial;

  modport master (
    output sb_read, sc_read, n_sb_write, sc_write,
    input  int_serial
  );

  modport slave (
    input  sb_read, sc_read, n_sb_write, sc_write,
    output int_serial
  );

endinterface

// File: rtl/serial_edge_sync.sv
// rtl/serial_edge_sync.sv - input synchronizer and rise/fall pulse detector
// Purpose: serial_sync is a STAGES-deep flop chain (0 = pass-through);
//          serial_edge_sync adds one-cycle rise/fall pulses on the synced level.
// Ports: clk2, reset, i_in (raw input), o_level (synced), o_rise/o_fall (pulses).
module serial_sync #(
  parameter int STAGES = 2
) (
  input  logic clk2,
  input  logic reset,
  input  logic i_in,
  output logic o_level
);

  generate
    if (STAGES == 0) begin : g_pass
      assign o_level = i_in;
    end else begin : g_chain
      logic [STAGES-1:0] r_sync;

      // Reset to 1 so an idle-high pad never looks like a falling edge.
      always_ff @(posedge clk2) begin
        if (reset) begin
          r_sync <= '1;
        end else begin
          r_sync[0] <= i_in;
          for (int i = 1; i < STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign o_level = r_sync[STAGES-1];
    end
  endgenerate

endmodule

module serial_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk2,
  input  logic reset,
  input  logic i_in,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;
  logic w_level;

  serial_sync #(.STAGES(STAGES)) u_sync (
    .clk2    (clk2),
    .reset   (reset),
    .i_in    (i_in),
    .o_level (w_level)
  );

  always_ff @(posedge clk2) begin
    if (reset) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/serial_link.sv
// rtl/serial_link.sv - SB/SC serial port responder with 8-bit shift engine
// Purpose: serves SB/SC reads and writes on d, shifts 8 bits on an internal
//          (lfo-derived) or external SCK, and raises int_serial on completion.
// Ports: clk2, reset; d (tristate data bus); bus (serial_if.slave strobes + int_serial);
//        lfo_16384Hz (internal half-bit tick); sck_in, sin (async pads);
//        sck_out, sck_oe, sout (pad outputs).
module serial_link
  import serial_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk2,
  input  logic       reset,
  inout  wire  [7:0] d,
  serial_if.slave    bus,
  input  logic       lfo_16384Hz,
  input  logic       sck_in,
  input  logic       sin,
  output logic       sck_out,
  output logic       sck_oe,
  output logic       sout
);

  logic [7:0]             r_sb;
  logic                   r_start;
  logic                   r_clk_sel;
  logic [BIT_COUNT_W-1:0] r_count;
  logic                   r_sck;
  logic                   r_sout;
  logic                   r_int;

  logic w_lfo_rise, w_lfo_fall, w_lfo_level;
  logic w_sck_rise, w_sck_fall, w_sck_level;
  logic w_sin;
  logic w_int_run, w_ext_run;
  logic w_shift_fall, w_shift_rise, w_done;
  logic w_d_oe;
  logic [7:0] w_d_out;

  serial_edge_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk2    (clk2),
    .reset   (reset),
    .i_in    (sck_in),
    .o_level (w_sck_level),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  // lfo is already in the clk2 domain, so only the edge detector is needed.
  serial_edge_sync #(.STAGES(0)) u_lfo_edge (
    .clk2    (clk2),
    .reset   (reset),
    .i_in    (lfo_16384Hz),
    .o_level (w_lfo_level),
    .o_rise  (w_lfo_rise),
    .o_fall  (w_lfo_fall)
  );

  serial_sync #(.STAGES(SYNC_STAGES)) u_sin_sync (
    .clk2    (clk2),
    .reset   (reset),
    .i_in    (sin),
    .o_level (w_sin)
  );

  assign w_int_run = r_start & r_clk_sel;
  assign w_ext_run = r_start & ~r_clk_sel;

  // In internal mode each lfo rise toggles SCK; the current SCK level tells
  // whether that toggle is a falling or a rising shift edge.
  assign w_shift_fall = (w_int_run & w_lfo_rise & r_sck) | (w_ext_run & w_sck_fall);
  assign w_shift_rise = (w_int_run & w_lfo_rise & ~r_sck) | (w_ext_run & w_sck_rise);
  assign w_done       = w_shift_rise & (r_count == {BIT_COUNT_W{1'b1}});

  always_ff @(posedge clk2) begin
    if (reset) begin
      r_sb      <= SB_RESET;
      r_start   <= 1'b0;
      r_clk_sel <= 1'b0;
      r_count   <= '0;
      r_sck     <= 1'b1;
      r_sout    <= 1'b1;
      r_int     <= 1'b0;
    end else begin
      r_int <= 1'b0;
      if (bus.sc_write) begin
        // An SC write restarts from idle and swallows any edge (and any
        // completion) landing in the same cycle.
        r_start   <= d[SC_START_BIT];
        r_clk_sel <= d[SC_CLKSEL_BIT];
        r_count   <= '0;
        r_sck     <= 1'b1;
      end else begin
        if (w_int_run && w_lfo_rise) begin
          r_sck <= ~r_sck;
        end
        if (w_shift_fall) begin
          r_sout <= r_sb[7];
        end
        if (w_shift_rise) begin
          r_sb    <= {r_sb[6:0], w_sin};
          r_count <= r_count + 1'b1;
        end
        if (w_done) begin
          r_start <= 1'b0;
          r_int   <= 1'b1;
        end
      end
      // Placed last so a CPU write beats a same-cycle shift; the count above still advances.
      if (!bus.n_sb_write) begin
        r_sb <= d;
      end
    end
  end

  // SB wins if both read strobes are (illegally) high together.
  assign w_d_oe  = bus.sb_read | bus.sc_read;
  assign w_d_out = bus.sb_read ? r_sb : sc_read_value(r_start, r_clk_sel);
  assign d       = w_d_oe ? w_d_out : 8'hzz;

  assign sck_out        = r_sck;
  assign sck_oe         = r_clk_sel;
  assign sout           = r_sout;
  assign bus.int_serial = r_int;

endmodule
